hazard_sched: RTL and testbench
===============================

// Module: hazard_sched
// PURPOSE
//  Pipeline sequencer for the 5-stage RISC-V core. Drives stall/flush for F/D/E/M/W and forwarding selects.
//  Consumes the E-stage redirect (PCSrcE from the branch decoder) and a data-memory ready handshake.
//  Holds a memory-wait FSM with timeout and saturating perf counters (stall and redirect cycles).
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive wait cycles before abort (>=1)
//  CNT_W        16  width of perf counters
// PORTS
//  clk         in   1      core clock; all state on posedge
//  rst         in   1      synchronous, active-high reset
//  Rs1D,Rs2D   in   5      source regs of instr in D
//  Rs1E,Rs2E   in   5      source regs of instr in E
//  RdE,RdM,RdW in   5      dest regs in E/M/W
//  RegWriteM   in   1      M instr writes RF
//  RegWriteW   in   1      W instr writes RF
//  ResultSrcE0 in   1      E instr is a load
//  PCSrcE      in   2      00 seq, 01 branch/jal taken, 10 jalr
//  MemReqM     in   1      M instr accesses data memory
//  MemReadyM   in   1      data memory completes access this cycle
//  StallF/D/E/M out 1      hold pipeline register of stage
//  FlushD/E/W  out  1      load bubble into stage register
//  ForwardAE   out  2      00 RF, 01 from W result, 10 from M ALU result
//  ForwardBE   out  2      same, for Rs2E
//  MemErr      out  1      sticky: memory wait timed out
//  StallCnt    out  CNT_W  cycles with any stall asserted
//  FlushCnt    out  CNT_W  cycles a redirect flush was issued
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=RUN, wait_cnt=0, MemErr=0, both counters=0.
//   While rst=1 outputs forced: Stall*=0, FlushD=FlushE=FlushW=1, Forward*=00.
//  Forwarding (comb, always active): ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
//   Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 00. M beats W. ForwardBE likewise on Rs2E.
//  freeze = MemReqM && !MemReadyM && !timeout; timeout = (state==WAIT && wait_cnt==MEM_TIMEOUT-1).
//  lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//  redirect = (PCSrcE!=00).
//  Priority, highest first:
//   1 freeze: StallF=D=E=M=1, FlushW=1, FlushD=FlushE=0. lwStall/redirect deferred; E holds, so PCSrcE re-seen on release.
//   2 redirect: FlushD=FlushE=1, StallF=StallD=0. Squashes D, so lwStall ignored.
//   3 lwStall: StallF=StallD=1, FlushE=1.
//   4 none: all Stall/Flush 0.
//  Stall/flush/forward outputs are combinational from inputs + state. Zero latency.
//  FSM (registered):
//   RUN: MemReqM && !MemReadyM -> WAIT, wait_cnt<=0 (freeze asserted this cycle).
//   WAIT: MemReadyM -> RUN.
//   WAIT: else if timeout -> RUN, MemErr<=1.
//    Timeout cycle: all stalls 0, FlushW=1; M instr retires as bubble.
//   WAIT: else wait_cnt<=wait_cnt+1.
//   MemReqM dropping in WAIT -> RUN, no error.
//  MEM_TIMEOUT=1: first miss cycle freezes; second cycle times out.
//  MemErr cleared only by rst.
//  Counters:
//   StallCnt+=1 on any cycle with any Stall* =1.
//   FlushCnt+=1 on any cycle with redirect flush issued (priority 2).
//   Both saturate at all-ones, never wrap.
//  rst mid-WAIT: FSM returns to RUN next edge; no MemErr set.
// TESTING
//  T1 RdM=5,RegWriteM=1,Rs1E=5; RdW=5,RegWriteW=1 -> ForwardAE=10. RdM=0 -> ForwardAE=01.
//   Rs2E=0 -> ForwardBE=00.
//  T2 ResultSrcE0=1,RdE=7,Rs2D=7,PCSrcE=00 -> StallF=StallD=FlushE=1 one cycle; StallCnt +1.
//  T3 Same as T2 plus PCSrcE=10 -> FlushD=FlushE=1, StallF=StallD=0; FlushCnt +1.
//  T4 MemReqM=1,MemReadyM=0 for 3 cycles then 1, PCSrcE=01 held:
//   StallF..M=1 and FlushW=1 for 3 cycles, no FlushD. Cycle 4 FlushD=FlushE=1; MemErr=0; StallCnt=3.
//  T5 MEM_TIMEOUT=4, MemReadyM=0 forever:
//   freeze cycles 1-4, cycle 5 stalls 0/FlushW=1, MemErr=1 sticky; counter stops at 4 for that miss.
//  T6 CNT_W=4, 20 lwStall cycles -> StallCnt=15. Assert rst mid-WAIT -> state RUN, counters 0, MemErr 0.

Source files
------------

// File: rtl/hazard_sched.sv
// Pipeline hazard sequencer for the 5-stage core: stall/flush/forward control,
// data-memory wait FSM with timeout abort, and saturating stall/redirect counters.
module hazard_sched #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcE0,
   input  logic [1:0]       PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam int unsigned WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

   typedef enum logic {S_RUN, S_WAIT} state_t;

   state_t         state;
   logic [WCW-1:0] wait_cnt;

   logic mem_miss;
   logic timeout;
   logic abort;
   logic freeze;
   logic lw_stall;
   logic redirect;
   logic redirect_flush;
   logic any_stall;

   assign mem_miss = MemReqM && !MemReadyM;
   assign timeout  = (state == S_WAIT) && (wait_cnt == WAIT_LAST);
   // Abort only when the miss is actually still pending in the timeout cycle.
   assign abort    = timeout && mem_miss;
   assign freeze   = mem_miss && !timeout;
   assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign redirect = (PCSrcE != 2'b00);

   // Hazard priority: reset > freeze > redirect > load-use.
   always_comb begin
      StallF         = 1'b0;
      StallD         = 1'b0;
      StallE         = 1'b0;
      StallM         = 1'b0;
      FlushD         = 1'b0;
      FlushE         = 1'b0;
      FlushW         = 1'b0;
      ForwardAE      = 2'b00;
      ForwardBE      = 2'b00;
      redirect_flush = 1'b0;

      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;

      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;

      if (rst) begin
         FlushD    = 1'b1;
         FlushE    = 1'b1;
         FlushW    = 1'b1;
         ForwardAE = 2'b00;
         ForwardBE = 2'b00;
      end else if (freeze) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         // On abort the M instruction retires as a bubble; E still advances normally.
         if (abort) FlushW = 1'b1;
         if (redirect) begin
            FlushD         = 1'b1;
            FlushE         = 1'b1;
            redirect_flush = 1'b1;
         end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   assign any_stall = StallF || StallD || StallE || StallM;

   // Memory-wait FSM, sticky error flag and saturating perf counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_RUN;
         wait_cnt <= '0;
         MemErr   <= 1'b0;
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (mem_miss) begin
                  state    <= S_WAIT;
                  wait_cnt <= '0;
               end
            end
            S_WAIT: begin
               if (!mem_miss) begin
                  state <= S_RUN;
               end else if (timeout) begin
                  state  <= S_RUN;
                  MemErr <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            default: state <= S_RUN;
         endcase

         if (any_stall && (StallCnt != {CNT_W{1'b1}}))
            StallCnt <= StallCnt + CNT_W'(1);
         if (redirect_flush && (FlushCnt != {CNT_W{1'b1}}))
            FlushCnt <= FlushCnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: main instance (MEM_TIMEOUT=4, CNT_W=4) plus a
// MEM_TIMEOUT=1 instance sharing the same stimulus.
module tb_hazard_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
   logic       regwritem, regwritew, resultsrce0, memreqm, memreadym;
   logic [1:0] pcsrce;

   logic       stallf, stalld, stalle, stallm, flushd, flushe, flushw;
   logic [1:0] fwa, fwb;
   logic       memerr;
   logic [3:0] stallcnt, flushcnt;

   logic        stallf1, stalld1, stalle1, stallm1, flushd1, flushe1, flushw1;
   logic [1:0]  fwa1, fwb1;
   logic        memerr1;
   logic [15:0] stallcnt1, flushcnt1;

   logic [6:0] ctl, ctl1;
   assign ctl  = {stallf, stalld, stalle, stallm, flushd, flushe, flushw};
   assign ctl1 = {stallf1, stalld1, stalle1, stallm1, flushd1, flushe1, flushw1};

   int vecs = 0;
   int errs = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   always #5 clk = ~clk;

   hazard_sched #(.MEM_TIMEOUT(4), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst),
      .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
      .RdE(rde), .RdM(rdm), .RdW(rdw),
      .RegWriteM(regwritem), .RegWriteW(regwritew), .ResultSrcE0(resultsrce0),
      .PCSrcE(pcsrce), .MemReqM(memreqm), .MemReadyM(memreadym),
      .StallF(stallf), .StallD(stalld), .StallE(stalle), .StallM(stallm),
      .FlushD(flushd), .FlushE(flushe), .FlushW(flushw),
      .ForwardAE(fwa), .ForwardBE(fwb),
      .MemErr(memerr), .StallCnt(stallcnt), .FlushCnt(flushcnt)
   );

   hazard_sched #(.MEM_TIMEOUT(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst),
      .Rs1D(rs1d), .Rs2D(rs2d), .Rs1E(rs1e), .Rs2E(rs2e),
      .RdE(rde), .RdM(rdm), .RdW(rdw),
      .RegWriteM(regwritem), .RegWriteW(regwritew), .ResultSrcE0(resultsrce0),
      .PCSrcE(pcsrce), .MemReqM(memreqm), .MemReadyM(memreadym),
      .StallF(stallf1), .StallD(stalld1), .StallE(stalle1), .StallM(stallm1),
      .FlushD(flushd1), .FlushE(flushe1), .FlushW(flushw1),
      .ForwardAE(fwa1), .ForwardBE(fwb1),
      .MemErr(memerr1), .StallCnt(stallcnt1), .FlushCnt(flushcnt1)
   );

   function automatic int sat4(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic idle_inputs();
      rs1d = 5'd0; rs2d = 5'd0; rs1e = 5'd0; rs2e = 5'd0;
      rde = 5'd0; rdm = 5'd0; rdw = 5'd0;
      regwritem = 1'b0; regwritew = 1'b0; resultsrce0 = 1'b0;
      pcsrce = 2'b00; memreqm = 1'b0; memreadym = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      rdm = 5'd5; regwritem = 1'b1; rs1e = 5'd5;
      memreqm = 1'b1; resultsrce0 = 1'b1; rde = 5'd3; rs1d = 5'd3;
      #1;
      vecs++;
      if (ctl !== 7'b0000111) begin
         errs++; $display("FAIL reset_ctl: got %b want %b", ctl, 7'b0000111);
      end
      vecs++;
      if (fwa !== 2'b00) begin
         errs++; $display("FAIL reset_fwd: got %b want 00", fwa);
      end
      @(negedge clk);
      vecs++;
      if ({memerr, stallcnt, flushcnt} !== 9'd0) begin
         errs++; $display("FAIL reset_regs: memerr=%b stallcnt=%0d flushcnt=%0d want 0/0/0",
                          memerr, stallcnt, flushcnt);
      end
      idle_inputs();
      rst = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
   endtask

   task automatic test_forward();
      @(negedge clk);
      idle_inputs();
      rdm = 5'd5; regwritem = 1'b1; rs1e = 5'd5; rdw = 5'd5; regwritew = 1'b1;
      #1;
      vecs++;
      if (fwa !== 2'b10) begin errs++; $display("FAIL fwd_m_beats_w: got %b want 10", fwa); end
      rdm = 5'd0;
      #1;
      vecs++;
      if (fwa !== 2'b01) begin errs++; $display("FAIL fwd_w_rdm0: got %b want 01", fwa); end
      rdw = 5'd0; rs2e = 5'd0;
      #1;
      vecs++;
      if ({fwa, fwb} !== 4'b0000) begin
         errs++; $display("FAIL fwd_x0: got %b/%b want 00/00", fwa, fwb);
      end
      rdm = 5'd9; rdw = 5'd9; rs2e = 5'd9; regwritem = 1'b0;
      #1;
      vecs++;
      if (fwb !== 2'b01) begin errs++; $display("FAIL fwdb_w_no_regwritem: got %b want 01", fwb); end
      regwritem = 1'b1;
      #1;
      vecs++;
      if (fwb !== 2'b10) begin errs++; $display("FAIL fwdb_m: got %b want 10", fwb); end
      vecs++;
      if (ctl !== 7'b0000000) begin errs++; $display("FAIL fwd_no_ctl: got %b want 0000000", ctl); end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      idle_inputs();
      resultsrce0 = 1'b1; rde = 5'd7; rs2d = 5'd7;
      #1;
      vecs++;
      if (ctl !== 7'b1100010) begin errs++; $display("FAIL lwstall_ctl: got %b want 1100010", ctl); end
      exp_stall = sat4(exp_stall + 1);
      @(negedge clk);
      idle_inputs();
      resultsrce0 = 1'b1; rde = 5'd0; rs1d = 5'd0;
      #1;
      vecs++;
      if (ctl !== 7'b0000000) begin errs++; $display("FAIL lwstall_rd0: got %b want 0000000", ctl); end
      vecs++;
      if (stallcnt !== 4'(exp_stall)) begin
         errs++; $display("FAIL lwstall_cnt: got %0d want %0d", stallcnt, exp_stall);
      end
   endtask

   task automatic test_redirect();
      @(negedge clk);
      idle_inputs();
      resultsrce0 = 1'b1; rde = 5'd7; rs2d = 5'd7; pcsrce = 2'b10;
      #1;
      vecs++;
      if (ctl !== 7'b0000110) begin errs++; $display("FAIL redirect_jalr: got %b want 0000110", ctl); end
      exp_flush = sat4(exp_flush + 1);
      @(negedge clk);
      pcsrce = 2'b01; resultsrce0 = 1'b0;
      #1;
      vecs++;
      if (ctl !== 7'b0000110) begin errs++; $display("FAIL redirect_br: got %b want 0000110", ctl); end
      exp_flush = sat4(exp_flush + 1);
      @(negedge clk);
      idle_inputs();
      #1;
      vecs++;
      if ({stallcnt, flushcnt} !== {4'(exp_stall), 4'(exp_flush)}) begin
         errs++; $display("FAIL redirect_cnt: got %0d/%0d want %0d/%0d",
                          stallcnt, flushcnt, exp_stall, exp_flush);
      end
   endtask

   task automatic test_mem_wait();
      pulse_reset();
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         idle_inputs();
         pcsrce = 2'b01; memreqm = 1'b1; memreadym = (c == 4);
         #1;
         vecs++;
         if (c < 4 && ctl !== 7'b1111001) begin
            errs++; $display("FAIL memwait_freeze c%0d: got %b want 1111001", c, ctl);
         end else if (c == 4 && ctl !== 7'b0000110) begin
            errs++; $display("FAIL memwait_release: got %b want 0000110", ctl);
         end
      end
      @(negedge clk);
      idle_inputs();
      #1;
      vecs++;
      if ({memerr, stallcnt, flushcnt} !== {1'b0, 4'd3, 4'd1}) begin
         errs++; $display("FAIL memwait_regs: memerr=%b stall=%0d flush=%0d want 0/3/1",
                          memerr, stallcnt, flushcnt);
      end
   endtask

   task automatic test_timeout();
      pulse_reset();
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         idle_inputs();
         memreqm = 1'b1;
         #1;
         vecs++;
         if (c < 5 && ctl !== 7'b1111001) begin
            errs++; $display("FAIL timeout_freeze c%0d: got %b want 1111001", c, ctl);
         end else if (c == 5 && ctl !== 7'b0000001) begin
            errs++; $display("FAIL timeout_abort: got %b want 0000001", ctl);
         end
         if (c == 1) begin
            vecs++;
            if (ctl1 !== 7'b1111001) begin
               errs++; $display("FAIL t1_freeze: got %b want 1111001", ctl1);
            end
         end else if (c == 2) begin
            vecs++;
            if (ctl1 !== 7'b0000001) begin
               errs++; $display("FAIL t1_abort: got %b want 0000001", ctl1);
            end
         end else if (c == 3) begin
            vecs++;
            if (memerr1 !== 1'b1) begin
               errs++; $display("FAIL t1_memerr: got %b want 1", memerr1);
            end
         end
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle_inputs();
         #1;
      end
      vecs++;
      if ({memerr, stallcnt, ctl} !== {1'b1, 4'd4, 7'b0000000}) begin
         errs++; $display("FAIL timeout_sticky: memerr=%b stall=%0d ctl=%b want 1/4/0000000",
                          memerr, stallcnt, ctl);
      end
   endtask

   task automatic test_saturate_and_reset();
      pulse_reset();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         idle_inputs();
         resultsrce0 = 1'b1; rde = 5'd12; rs1d = 5'd12;
         exp_stall = sat4(exp_stall + 1);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      vecs++;
      if (stallcnt !== 4'(exp_stall)) begin
         errs++; $display("FAIL stall_saturate: got %0d want %0d", stallcnt, exp_stall);
      end
      // Enter WAIT with a partially advanced wait counter, then reset.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         memreqm = 1'b1;
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      vecs++;
      if ({memerr, stallcnt, flushcnt} !== 9'd0) begin
         errs++; $display("FAIL midwait_rst: memerr=%b stall=%0d flush=%0d want 0/0/0",
                          memerr, stallcnt, flushcnt);
      end
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) begin
            @(negedge clk);
            #1;
         end
         vecs++;
         if (c < 5 && ctl !== 7'b1111001) begin
            errs++; $display("FAIL postrst_freeze c%0d: got %b want 1111001", c, ctl);
         end else if (c == 5 && ctl !== 7'b0000001) begin
            errs++; $display("FAIL postrst_abort: got %b want 0000001", ctl);
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_forward();
      test_load_use();
      test_redirect();
      test_mem_wait();
      test_timeout();
      test_saturate_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
